// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder: tracks a Johnson ring counter's code, locks onto the legal sequence,
// and reports the phase, completed revolutions and a sticky error for illegal or out-of-order codes.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   jc_in         Johnson code sampled when in_valid is high
//   in_valid      sample qualifier
//   clr_err       leaves ERROR for SEARCH
//   phase_onehot  one-hot phase, zero unless locked
//   phase_idx     last legal decoded index
//   locked        decoder is tracking a legal sequence
//   err           sticky error flag, high exactly while in ERROR
//   rev_tick      one-cycle pulse when a locked sequence wraps from N-1 to 0
//   rev_count     wrapping revolution counter
//   stall         only with JPD_STALL_DET_EN: one-cycle pulse when a locked code holds for STALL_MAX samples
module johnson_phase_decoder #(
  parameter int WIDTH = 5,
  parameter int IDX_W = 4,
  parameter int REV_W = 8,
  parameter int LOCK_CNT = 2
`ifdef JPD_STALL_DET_EN
  , parameter int STALL_MAX = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     jc_in,
  input  logic                 in_valid,
  input  logic                 clr_err,
  output logic [2*WIDTH-1:0]   phase_onehot,
  output logic [IDX_W-1:0]     phase_idx,
  output logic                 locked,
  output logic                 err,
  output logic                 rev_tick,
  output logic [REV_W-1:0]     rev_count
`ifdef JPD_STALL_DET_EN
  , output logic               stall
`endif
);
  localparam int N = 2 * WIDTH;
  localparam int GC_W = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCKED, S_ERROR} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx, succ;
  logic [GC_W-1:0] gc_q, gc_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic tick_q, tick_d, legal, succ_hit, hold;
`ifdef JPD_STALL_DET_EN
  localparam int SC_W = $clog2(STALL_MAX + 1);
  logic [SC_W-1:0] sc_q, sc_d;
  logic stall_q, stall_d;
`endif
  // Rising half of the ring is (1<<k)-1; falling half is all-ones with the low m bits cleared.
  always_comb begin
    legal = 1'b0;
    idx = '0;
    for (int k = 0; k <= WIDTH; k++)
      if (jc_in == WIDTH'((1 << k) - 1)) begin
        legal = 1'b1;
        idx = IDX_W'(k);
      end
    for (int m = 1; m < WIDTH; m++)
      if (jc_in == WIDTH'({WIDTH{1'b1}} << m)) begin
        legal = 1'b1;
        idx = IDX_W'(WIDTH + m);
      end
  end
  // Each legal index has a unique code, so comparing indices against the last legal one
  // is equivalent to comparing codes against the previous sample.
  assign succ = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
  assign succ_hit = legal && (idx == succ);
  assign hold = legal && (idx == idx_q);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    gc_d = gc_q;
    tick_d = 1'b0;
    rev_d = rev_q;
`ifdef JPD_STALL_DET_EN
    sc_d = (state_q == S_LOCKED) ? sc_q : '0;
    stall_d = 1'b0;
`endif
    if (state_q == S_ERROR) begin
      // A clear wins unless an illegal code arrives in the same cycle.
      if (clr_err && !(in_valid && !legal)) state_d = S_SEARCH;
    end else if (in_valid && !legal) begin
      state_d = S_ERROR;
    end else if (in_valid) begin
      idx_d = idx;
      if (state_q == S_SEARCH) begin
        state_d = S_TRACK;
        gc_d = '0;
      end else if (state_q == S_TRACK) begin
        gc_d = succ_hit ? gc_q + 1'b1 : hold ? gc_q : '0;
        if (succ_hit && (gc_q + 1'b1) == GC_W'(LOCK_CNT)) state_d = S_LOCKED;
      end else if (succ_hit) begin
        if (idx_q == IDX_W'(N - 1)) begin
          tick_d = 1'b1;
          rev_d = rev_q + 1'b1;
        end
`ifdef JPD_STALL_DET_EN
        sc_d = '0;
`endif
      end else if (!hold) begin
        state_d = S_ERROR;
      end
`ifdef JPD_STALL_DET_EN
      else begin
        sc_d = sc_q + 1'b1;
        if (sc_d == SC_W'(STALL_MAX)) begin
          state_d = S_SEARCH;
          stall_d = 1'b1;
          sc_d = '0;
        end
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_SEARCH;
      idx_q <= '0;
      gc_q <= '0;
      tick_q <= 1'b0;
      rev_q <= '0;
`ifdef JPD_STALL_DET_EN
      sc_q <= '0;
      stall_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      gc_q <= gc_d;
      tick_q <= tick_d;
      rev_q <= rev_d;
`ifdef JPD_STALL_DET_EN
      sc_q <= sc_d;
      stall_q <= stall_d;
`endif
    end
  end
  assign locked = (state_q == S_LOCKED);
  assign err = (state_q == S_ERROR);
  assign phase_idx = idx_q;
  assign phase_onehot = locked ? ({{(N - 1){1'b0}}, 1'b1} << idx_q) : '0;
  assign rev_tick = tick_q;
  assign rev_count = rev_q;
`ifdef JPD_STALL_DET_EN
  assign stall = stall_q;
`endif
endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the 5-bit Johnson ring counter.
- Samples the counter's code and checks that every step follows the legal Johnson sequence.
- Locks onto the sequence and emits a one-hot phase strobe, a phase index and a revolution count.
- Flags any illegal or out-of-order code with a sticky error. The output feeds phase-gated logic in the Register/ALU path.

Parameters:
- WIDTH, 5, Johnson counter width; number of states N = 2*WIDTH.
- IDX_W, 4, phase index width; must satisfy 2^IDX_W >= 2*WIDTH.
- REV_W, 8, revolution counter width.
- LOCK_CNT, 2, consecutive legal successor steps required to reach LOCKED.
- STALL_MAX, 16, optional-feature stall limit, in samples.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- jc_in  in  WIDTH  Johnson code from the counter.
- in_valid  in  1  sample jc_in this cycle.
- clr_err  in  1  single-cycle pulse; leaves ERROR.
- phase_onehot  out  2*WIDTH  one-hot current phase; all zero unless locked.
- phase_idx  out  IDX_W  last legal decoded index, 0..2*WIDTH-1.
- locked  out  1  decoder tracking a legal sequence.
- err  out  1  sticky error flag.
- rev_tick  out  1  one-cycle pulse on each completed revolution.
- rev_count  out  REV_W  revolution counter, wraps.
- stall  out  1  present only with JPD_STALL_DET_EN.

Behaviour:
- Code map, for k = 0..WIDTH:
  - index k is code (1<<k)-1.
  - index WIDTH+m (m = 1..WIDTH-1) is all-ones with the low m bits cleared.
  - Example for WIDTH=5: 00000(0), 00001(1), 00011(2), 00111(3), 01111(4), 11111(5), 11110(6), 11100(7), 11000(8), 10000(9).
  - Any other code is illegal.
- Successor of index i is (i+1) mod N. "Hold" means the code equals the previous sample.
- Reset (async, immediate, also mid-operation):
  - State = SEARCH.
  - All outputs 0. Internal prev index, good_cnt and stall counter cleared.
- Latency: all outputs are registered and reflect the in_valid sample one clock later. When in_valid=0, state and outputs hold, except rev_tick, which returns to 0.
- FSM states and transitions:
  - SEARCH:
    - legal code -> TRACK; prev=idx, good_cnt=0.
    - illegal code -> ERROR.
  - TRACK:
    - successor -> good_cnt+1; when good_cnt reaches LOCK_CNT -> LOCKED.
    - hold -> no change.
    - legal non-successor -> good_cnt=0, prev=idx, stay in TRACK.
    - illegal -> ERROR.
  - LOCKED:
    - successor -> advance.
    - hold -> no change.
    - legal non-successor or illegal -> ERROR.
  - ERROR:
    - hold here until clr_err=1 -> SEARCH. The sample taken in that same cycle is ignored.
- err:
  - Set on entry to ERROR; cleared only when ERROR -> SEARCH.
  - clr_err in any other state has no effect.
  - clr_err together with in_valid and an illegal code while in ERROR: stays in ERROR, err stays 1.
- locked = 1 exactly while in LOCKED.
- phase_onehot = locked ? (1 << phase_idx) : 0.
- phase_idx: updates on every legal sample in SEARCH, TRACK and LOCKED; holds in ERROR.
- rev_tick:
  - Asserted for one cycle when LOCKED advances from index N-1 to 0.
  - rev_count increments on the same edge and wraps from 2^REV_W-1 to 0.
  - rev_count is cleared only by reset.

Optional Feature:
JPD_STALL_DET_EN
- Defined:
  - An internal counter counts consecutive hold samples while LOCKED; it is cleared on any successor sample.
  - When the count reaches STALL_MAX: go to SEARCH, drop locked, pulse stall for one cycle. err is unaffected.
  - stall resets to 0.
- Undefined: no stall counter and no stall port; holds are tolerated indefinitely.

Test Plan:
- Release reset, drive the legal sequence 00000, 00001, 00011 with in_valid=1 -> locked=1 one cycle after the third sample; phase_onehot=0x004, phase_idx=2.
- While locked, feed 10 more legal steps through 10000 -> 00000 -> rev_tick pulses exactly once at the wrap and rev_count goes 0 -> 1. Run 256 revolutions -> rev_count wraps to 0.
- While locked at 00111, drive 01111 three times (hold) then 11111 -> no error; phase_idx 4 then 5.
- While locked at index 3, drive 11100 (legal, index 7) -> err=1, locked=0, phase_onehot=0. Then pulse clr_err -> SEARCH, err=0. A following 00000 sample -> TRACK.
- Drive illegal 00101 in SEARCH -> err=1. Drive clr_err with illegal 01010 in the same cycle -> err stays 1. Assert reset low mid-ERROR -> all outputs 0 immediately, before the next clk edge.
- With JPD_STALL_DET_EN and STALL_MAX=16: lock, then hold 16 samples -> stall pulses once, locked=0, err=0.
